// File: rtl/instr_queue_pkg.sv
// instr_queue_pkg: shared types and constants for the instruction queue.
//   - Stage-1 instruction structs handed to the dcache, regfile and math
//     pipeline.
//   - Opcode values and the bit-field positions of the 16-bit host word.
//   - decode(): maps one host word onto the three stage-1 structs.
package instr_queue_pkg;

  localparam int WORD_W = 16;

  // Opcodes, word[15:13]. 3'b110 and 3'b111 are illegal.
  localparam logic [2:0] OP_NOP         = 3'b000;
  localparam logic [2:0] OP_CACHE_LOAD  = 3'b001;
  localparam logic [2:0] OP_CACHE_STORE = 3'b010;
  localparam logic [2:0] OP_MATH        = 3'b011;
  localparam logic [2:0] OP_DMA_LOAD    = 3'b100;
  localparam logic [2:0] OP_DMA_STORE   = 3'b101;

  // Bit-field positions inside the 16-bit word
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int REG_MSB  = 12;  // cache reg / math dst
  localparam int REG_LSB  = 11;
  localparam int ADDR_MSB = 10;  // cache / DMA address
  localparam int ADDR_LSB = 0;
  localparam int SRC_MSB  = 10;  // math src
  localparam int SRC_LSB  = 9;
  localparam int MOP_MSB  = 8;   // math op
  localparam int MOP_LSB  = 6;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic [1:0]  regfile_reg;
    logic [10:0] cache_addr;
  } regfile_instruction;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] src;
  } arithmetic_instruction;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic [10:0] cache_addr;
  } dma_stage_1_instr;

  typedef struct packed {
    regfile_instruction    cache;
    arithmetic_instruction arith;
    dma_stage_1_instr      dma;
    logic                  illegal;
  } decoded_t;

  // Decode one word. Structs that are not selected stay all-zero, so at
  // most one valid is ever high.
  function automatic decoded_t decode(input logic [WORD_W-1:0] word);
    decoded_t d;
    d = '0;
    case (word[OP_MSB:OP_LSB])
      OP_NOP: begin
        d = '0;
      end
      OP_CACHE_LOAD, OP_CACHE_STORE: begin
        d.cache.valid       = 1'b1;
        d.cache.is_load     = (word[OP_MSB:OP_LSB] == OP_CACHE_LOAD);
        d.cache.regfile_reg = word[REG_MSB:REG_LSB];
        d.cache.cache_addr  = word[ADDR_MSB:ADDR_LSB];
      end
      OP_MATH: begin
        d.arith.valid = 1'b1;
        d.arith.op    = word[MOP_MSB:MOP_LSB];
        d.arith.dst   = word[REG_MSB:REG_LSB];
        d.arith.src   = word[SRC_MSB:SRC_LSB];
      end
      OP_DMA_LOAD, OP_DMA_STORE: begin
        d.dma.valid      = 1'b1;
        d.dma.is_load    = (word[OP_MSB:OP_LSB] == OP_DMA_LOAD);
        d.dma.cache_addr = word[ADDR_MSB:ADDR_LSB];
      end
      default: begin
        // 110 / 111: behaves as a NOP but is flagged
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_queue_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
//   clk, reset   : clock, asynchronous active-high reset
//   push, wr_data: write request / data (ignored while full)
//   pop          : read request (ignored while empty)
//   rd_data      : head of queue (valid while !empty)
//   count        : occupancy, 0..DEPTH
//   full, empty  : derived from the registered count only
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; the array itself is not reset, occupancy says what is live
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop balance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_queue.sv
// instr_queue: host instruction FIFO plus stage-1 decoder.
//   clk, reset       : clock, asynchronous active-high reset
//   freeze           : pipeline stall; no pop, decoded outputs hold
//   wr_valid/wr_ready/wr_data : host push handshake (16-bit words)
//   cache_instr      : regfile load/store to the dcache
//   arithmetic_instr : math pipeline instruction
//   dma_instr        : DMA transfer request
//   empty, level     : FIFO occupancy (registered count)
//   illegal          : sticky, set when an illegal opcode is popped
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   freeze,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [15:0]            wr_data,
  output regfile_instruction     cache_instr,
  output arithmetic_instruction  arithmetic_instr,
  output dma_stage_1_instr       dma_instr,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   illegal
);

  logic [WORD_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  decoded_t          dec;

  // Pop is requested whenever unfrozen; the FIFO ignores it while empty,
  // so a word pushed into an empty queue pops one cycle later at the earliest.
  sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_valid),
    .pop     (!freeze),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wr_ready = !fifo_full;
  assign empty    = fifo_empty;
  assign dec      = decode(head);

  // Output register: hold on freeze, else issue the head or a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_instr      <= '0;
      arithmetic_instr <= '0;
      dma_instr        <= '0;
      illegal          <= 1'b0;
    end else if (!freeze) begin
      if (!fifo_empty) begin
        cache_instr      <= dec.cache;
        arithmetic_instr <= dec.arith;
        dma_instr        <= dec.dma;
        if (dec.illegal) illegal <= 1'b1;
      end else begin
        cache_instr      <= '0;
        arithmetic_instr <= '0;
        dma_instr        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;
  import instr_queue_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  freeze;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [15:0]           wr_data;
  regfile_instruction    cache_instr;
  arithmetic_instruction arithmetic_instr;
  dma_stage_1_instr      dma_instr;
  logic                  empty;
  logic [4:0]            level;
  logic                  illegal;

  int vectors;
  int miscompares;

  instr_queue #(.DEPTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .freeze           (freeze),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .cache_instr      (cache_instr),
    .arithmetic_instr (arithmetic_instr),
    .dma_instr        (dma_instr),
    .empty            (empty),
    .level            (level),
    .illegal          (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    freeze   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'h0000;
    cyc();
    cyc();

    // Reset state
    chk("rst_cache", 32'(cache_instr), 32'h0);
    chk("rst_arith", 32'(arithmetic_instr), 32'h0);
    chk("rst_dma", 32'(dma_instr), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    chk("rst_illegal", 32'(illegal), 32'h0);
    reset = 1'b0;
    cyc();

    // Load r0, addr 3: visible in level after push edge, issued next edge
    wr_valid = 1'b1;
    wr_data  = 16'h2003;
    cyc();
    wr_valid = 1'b0;
    chk("push1_level", 32'(level), 32'h1);
    chk("push1_empty", 32'(empty), 32'h0);
    chk("push1_no_bypass", 32'(cache_instr), 32'h0);
    cyc();
    chk("load_cache", 32'(cache_instr), 32'h6003);
    chk("load_empty", 32'(empty), 32'h1);
    chk("load_arith", 32'(arithmetic_instr), 32'h0);
    chk("load_dma", 32'(dma_instr), 32'h0);
    cyc();
    chk("bubble1", 32'(cache_instr), 32'h0);

    // Fill 16 words while frozen: loads with reg=i%4, addr=i
    freeze = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'h2000 | 16'((i % 4) << 11) | 16'(i);
      cyc();
    end
    chk("full_level", 32'(level), 32'd16);
    chk("full_wr_ready", 32'(wr_ready), 32'h0);
    wr_data = 16'h2055;  // 17th word, must be refused
    cyc();
    wr_valid = 1'b0;
    chk("full_17th_level", 32'(level), 32'd16);
    chk("frozen_outputs", 32'(cache_instr), 32'h0);
    freeze = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("drain_order", 32'(cache_instr), 32'h6000 | 32'((i % 4) << 11) | 32'(i));
    end
    cyc();
    chk("drain_bubble", 32'(cache_instr), 32'h0);
    chk("drain_empty", 32'(empty), 32'h1);

    // Math then DMA load then DMA store, back to back
    wr_valid = 1'b1;
    wr_data  = 16'h7A40;
    cyc();
    wr_data = 16'h8005;
    cyc();
    chk("math_arith", 32'(arithmetic_instr), 32'h9D);
    chk("math_cache", 32'(cache_instr), 32'h0);
    chk("math_dma", 32'(dma_instr), 32'h0);
    wr_data = 16'hA005;
    cyc();
    wr_valid = 1'b0;
    chk("dmald_dma", 32'(dma_instr), 32'h1805);
    chk("dmald_arith", 32'(arithmetic_instr), 32'h0);
    cyc();
    chk("dmast_dma", 32'(dma_instr), 32'h1005);
    cyc();
    chk("dma_bubble", 32'(dma_instr), 32'h0);

    // Store r1 addr 7, then freeze for 5 cycles with one word queued
    wr_valid = 1'b1;
    wr_data  = 16'h4807;
    cyc();
    wr_data = 16'h2001;
    cyc();
    wr_valid = 1'b0;
    freeze   = 1'b1;
    chk("store_cache", 32'(cache_instr), 32'h4807);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("freeze_hold", 32'(cache_instr), 32'h4807);
      chk("freeze_level", 32'(level), 32'h1);
    end
    freeze = 1'b0;
    cyc();
    chk("unfreeze_next", 32'(cache_instr), 32'h6001);
    cyc();
    chk("unfreeze_bubble", 32'(cache_instr), 32'h0);

    // Illegal opcode: bubble out, sticky flag
    wr_valid = 1'b1;
    wr_data  = 16'hC000;
    cyc();
    wr_data = 16'h2004;
    cyc();
    wr_valid = 1'b0;
    chk("illegal_cache", 32'(cache_instr), 32'h0);
    chk("illegal_arith", 32'(arithmetic_instr), 32'h0);
    chk("illegal_dma", 32'(dma_instr), 32'h0);
    chk("illegal_set", 32'(illegal), 32'h1);
    cyc();
    chk("illegal_next_cache", 32'(cache_instr), 32'h6004);
    chk("illegal_sticky1", 32'(illegal), 32'h1);
    cyc();
    chk("illegal_sticky2", 32'(illegal), 32'h1);

    // Queue 9 words, drain one, then async reset with level=8
    freeze = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'h2010 + 16'(i);
      cyc();
    end
    wr_valid = 1'b0;
    freeze   = 1'b0;
    cyc();
    chk("middrain_cache", 32'(cache_instr), 32'h6010);
    chk("middrain_level", 32'(level), 32'd8);
    #2;
    reset = 1'b1;
    #1;
    chk("async_cache", 32'(cache_instr), 32'h0);
    chk("async_empty", 32'(empty), 32'h1);
    chk("async_level", 32'(level), 32'h0);
    chk("async_illegal", 32'(illegal), 32'h0);
    chk("async_wr_ready", 32'(wr_ready), 32'h1);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("post_reset_cache", 32'(cache_instr), 32'h0);
      chk("post_reset_empty", 32'(empty), 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
